// File: rtl/gshare_predictor_pkg.sv
// Shared types, opcode encodings and immediate decoders for the gshare branch predictor.
package gshare_predictor_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;
  typedef logic [6:0]  opcode_t;

  localparam int      OPCODE_MSB = 6;
  localparam int      OPCODE_LSB = 0;
  localparam opcode_t OPCODE_JAL = 7'b1101111;
  localparam opcode_t OPCODE_BR  = 7'b1100011;

  typedef enum logic {
    GP_INIT = 1'b0,
    GP_RUN  = 1'b1
  } gp_state_e;

  // Sign-extended conditional-branch offset.
  function automatic addr_t b_imm(input inst_t inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  // Sign-extended jump offset.
  function automatic addr_t j_imm(input inst_t inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/gshare_predictor_sat_counter_next.sv
// Next value of a saturating up/down direction counter.
module sat_counter_next #(
  parameter int CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] cnt,
  input  logic                taken,
  output logic [CNT_BITS-1:0] cnt_next
);

  // NOTE: default first so every path assigns cnt_next and no latch is inferred.
  always_comb begin
    cnt_next = cnt;
    if (taken && (cnt != '1))
      cnt_next = cnt + CNT_BITS'(1);
    else if (!taken && (cnt != '0))
      cnt_next = cnt - CNT_BITS'(1);
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare/bimodal direction predictor with speculative global history and ROB-driven recovery.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int IDX_BITS = 8,
  parameter int CNT_BITS = 2,
  parameter int GHR_BITS = 8,
  parameter bit USE_GHR  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid_in,
  input  logic [31:0]         pred_pc_in,
  input  logic [31:0]         pred_inst_in,
  output logic                pred_ready_out,
  output logic                pred_taken_out,
  output logic [31:0]         pred_target_out,
  output logic [GHR_BITS-1:0] pred_ghr_out,
  input  logic                upd_valid_in,
  input  logic [31:0]         upd_pc_in,
  input  logic [GHR_BITS-1:0] upd_ghr_in,
  input  logic                upd_taken_in,
  input  logic                upd_mispredict_in
);

  localparam int                  DEPTH          = 2 ** IDX_BITS;
  localparam logic [CNT_BITS-1:0] WEAK_NOT_TAKEN = CNT_BITS'((2 ** (CNT_BITS - 1)) - 1);

  logic [CNT_BITS-1:0] pht [DEPTH];
  gp_state_e           state, state_next;
  logic [IDX_BITS-1:0] init_idx;
  logic [GHR_BITS-1:0] ghr;

  // Shift a new outcome into the youngest history position; also covers GHR_BITS == 1.
  function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] hist, input logic b);
    logic [GHR_BITS:0] tmp;
    tmp = {hist, b};
    return tmp[GHR_BITS-1:0];
  endfunction

  function automatic logic [IDX_BITS-1:0] hash_idx(input addr_t pc, input logic [GHR_BITS-1:0] hist);
    return USE_GHR ? (pc[IDX_BITS+1:2] ^ IDX_BITS'(hist)) : pc[IDX_BITS+1:2];
  endfunction

  // FSM: state register, next state, outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= GP_INIT;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if ((state == GP_INIT) && (&init_idx)) state_next = GP_RUN;
  end

  always_comb begin
    pred_ready_out = (state == GP_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  init_idx <= '0;
    else if (state == GP_INIT) init_idx <= init_idx + IDX_BITS'(1);
  end

  // Prediction path: zero latency, reads the table before any same-cycle update lands.
  opcode_t             opcode;
  logic                is_br, is_jal;
  logic [IDX_BITS-1:0] pred_idx;
  logic [CNT_BITS-1:0] pred_cnt;

  assign opcode   = pred_inst_in[OPCODE_MSB:OPCODE_LSB];
  assign is_br    = (opcode == OPCODE_BR);
  assign is_jal   = (opcode == OPCODE_JAL);
  assign pred_idx = hash_idx(pred_pc_in, ghr);
  assign pred_cnt = pht[pred_idx];

  always_comb begin
    pred_taken_out  = 1'b0;
    pred_target_out = pred_pc_in + 32'd4;
    if (is_jal) begin
      pred_taken_out  = pred_ready_out;
      pred_target_out = pred_pc_in + j_imm(pred_inst_in);
    end else if (is_br) begin
      pred_taken_out = pred_ready_out & pred_cnt[CNT_BITS-1];
      if (pred_taken_out) pred_target_out = pred_pc_in + b_imm(pred_inst_in);
    end
  end

  assign pred_ghr_out = ghr;

  // Commit-side counter update.
  logic [IDX_BITS-1:0] upd_idx;
  logic [CNT_BITS-1:0] upd_cnt, upd_cnt_next;

  assign upd_idx = hash_idx(upd_pc_in, upd_ghr_in);
  assign upd_cnt = pht[upd_idx];

  sat_counter_next #(.CNT_BITS(CNT_BITS)) u_sat (
    .cnt      (upd_cnt),
    .taken    (upd_taken_in),
    .cnt_next (upd_cnt_next)
  );

  // NOTE: the table has no reset; the INIT sweep writes every entry before any prediction is trusted.
  always_ff @(posedge clk) begin
    if (state == GP_INIT)  pht[init_idx] <= WEAK_NOT_TAKEN;
    else if (upd_valid_in) pht[upd_idx]  <= upd_cnt_next;
  end

  // History: a resolved mispredict overrides any same-cycle speculative shift.
  logic recover, spec_shift;

  assign recover    = upd_valid_in && upd_mispredict_in && (state == GP_RUN);
  assign spec_shift = pred_valid_in && pred_ready_out && is_br;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            ghr <= '0;
    else if (recover)    ghr <= shift_in(upd_ghr_in, upd_taken_in);
    else if (spec_shift) ghr <= shift_in(ghr, pred_taken_out);
  end

  logic unused_upd_pc_bits;
  assign unused_upd_pc_bits = ^{upd_pc_in[31:IDX_BITS+2], upd_pc_in[1:0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor (IDX=4, CNT=2, GHR=4) plus a bimodal instance.
module tb_gshare_predictor;

  logic        clk, rst;
  logic        pred_valid_in, upd_valid_in, upd_taken_in, upd_mispredict_in;
  logic [31:0] pred_pc_in, pred_inst_in, upd_pc_in;
  logic [3:0]  upd_ghr_in;
  logic        pred_ready_out, pred_taken_out;
  logic [31:0] pred_target_out;
  logic [3:0]  pred_ghr_out;
  logic        b_ready, b_taken;
  logic [31:0] b_target;
  logic [3:0]  b_ghr;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  gshare_predictor #(.IDX_BITS(4), .CNT_BITS(2), .GHR_BITS(4), .USE_GHR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .pred_valid_in(pred_valid_in), .pred_pc_in(pred_pc_in), .pred_inst_in(pred_inst_in),
    .pred_ready_out(pred_ready_out), .pred_taken_out(pred_taken_out),
    .pred_target_out(pred_target_out), .pred_ghr_out(pred_ghr_out),
    .upd_valid_in(upd_valid_in), .upd_pc_in(upd_pc_in), .upd_ghr_in(upd_ghr_in),
    .upd_taken_in(upd_taken_in), .upd_mispredict_in(upd_mispredict_in)
  );

  gshare_predictor #(.IDX_BITS(4), .CNT_BITS(2), .GHR_BITS(4), .USE_GHR(1'b0)) dut_bim (
    .clk(clk), .rst(rst),
    .pred_valid_in(pred_valid_in), .pred_pc_in(pred_pc_in), .pred_inst_in(pred_inst_in),
    .pred_ready_out(b_ready), .pred_taken_out(b_taken),
    .pred_target_out(b_target), .pred_ghr_out(b_ghr),
    .upd_valid_in(upd_valid_in), .upd_pc_in(upd_pc_in), .upd_ghr_in(upd_ghr_in),
    .upd_taken_in(upd_taken_in), .upd_mispredict_in(upd_mispredict_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] b_inst(input int imm);
    logic [12:0] i;
    i = imm[12:0];
    return {i[12], i[10:5], 5'd0, 5'd0, 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_inst(input int imm);
    logic [20:0] i;
    i = imm[20:0];
    return {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'b1101111};
  endfunction

  task automatic set_pred(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    pred_valid_in = v;
    pred_pc_in    = pc;
    pred_inst_in  = inst;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic [3:0] ghr,
                         input logic taken, input logic misp);
    upd_valid_in      = v;
    upd_pc_in         = pc;
    upd_ghr_in        = ghr;
    upd_taken_in      = taken;
    upd_mispredict_in = misp;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [3:0] ghr, input logic taken);
    set_upd(1'b1, pc, ghr, taken, 1'b0);
    tick();
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
  endtask

  // Counts cycles until ready; optionally injects mispredicting updates to pc 0x40 mid-sweep.
  task automatic wait_ready(input logic inject);
    int cnt;
    cnt = 0;
    while (!pred_ready_out && cnt < 100) begin
      if (inject && (cnt == 3 || cnt == 4)) set_upd(1'b1, 32'h40, 4'h5, 1'b1, 1'b1);
      else                                  set_upd(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      tick();
      cnt++;
    end
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    check("init_cycles", cnt, 16);
  endtask

  initial begin
    rst = 1'b0;
    set_pred(1'b0, 32'h0, NOP);
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    set_pred(1'b1, 32'h100, j_inst(32'h20));
    #1;
    check("rst_ready", pred_ready_out, 0);
    check("rst_taken_jal", pred_taken_out, 0);
    check("rst_ghr", pred_ghr_out, 0);
    set_pred(1'b0, 32'h0, NOP);
    rst = 1'b1;
    wait_ready(1'b0);

    // Freshly initialised entry is weakly not-taken.
    set_pred(1'b0, 32'h40, b_inst(8));
    #1;
    check("init_beq_taken", pred_taken_out, 0);
    check("init_beq_target", pred_target_out, 32'h44);
    check("init_ghr", pred_ghr_out, 0);

    // Saturation at the top and bottom of the counter.
    repeat (4) do_update(32'h40, 4'h0, 1'b1);
    set_pred(1'b0, 32'h40, b_inst(-8));
    #1;
    check("sat_hi_taken", pred_taken_out, 1);
    check("sat_hi_target", pred_target_out, 32'h38);
    do_update(32'h40, 4'h0, 1'b0);
    check("sat_hi_no_wrap", pred_taken_out, 1);
    do_update(32'h40, 4'h0, 1'b0);
    check("dec_to_1", pred_taken_out, 0);
    do_update(32'h40, 4'h0, 1'b0);
    do_update(32'h40, 4'h0, 1'b0);
    do_update(32'h40, 4'h0, 1'b1);
    check("sat_lo_no_wrap", pred_taken_out, 0);
    check("sat_lo_target", pred_target_out, 32'h44);
    do_update(32'h40, 4'h0, 1'b1);
    check("inc_to_2", pred_taken_out, 1);

    // Speculative history: taken BR, not-taken BR, JAL.
    set_pred(1'b1, 32'h40, b_inst(-8));
    #1;
    check("spec0_ghr", pred_ghr_out, 4'b0000);
    check("spec0_taken", pred_taken_out, 1);
    tick();
    set_pred(1'b1, 32'h80, b_inst(8));
    #1;
    check("spec1_ghr", pred_ghr_out, 4'b0001);
    check("spec1_taken", pred_taken_out, 0);
    tick();
    set_pred(1'b1, 32'h200, j_inst(32'h20));
    #1;
    check("spec2_ghr", pred_ghr_out, 4'b0010);
    check("spec2_jal_target", pred_target_out, 32'h220);
    tick();
    set_pred(1'b0, 32'h0, NOP);
    #1;
    check("spec_after_jal_ghr", pred_ghr_out, 4'b0010);

    // Recovery collides with a predicted-taken BR.
    set_pred(1'b1, 32'h08, b_inst(8));
    set_upd(1'b1, 32'h40, 4'b0101, 1'b1, 1'b1);
    #1;
    check("recov_pred_taken", pred_taken_out, 1);
    check("recov_pred_target", pred_target_out, 32'h10);
    tick();
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    set_pred(1'b0, 32'h38, b_inst(8));
    #1;
    check("recov_ghr", pred_ghr_out, 4'b1011);
    check("hash_idx5_taken", pred_taken_out, 1);

    // JAL targets, wrap, and non-branch fallthrough; none shift history.
    set_pred(1'b1, 32'h100, j_inst(32'h20));
    #1;
    check("jal_taken", pred_taken_out, 1);
    check("jal_target", pred_target_out, 32'h120);
    tick();
    set_pred(1'b1, 32'hFFFF_FFF0, j_inst(32'h20));
    #1;
    check("jal_wrap_target", pred_target_out, 32'h10);
    tick();
    set_pred(1'b1, 32'h100, NOP);
    #1;
    check("alu_taken", pred_taken_out, 0);
    check("alu_target", pred_target_out, 32'h104);
    tick();
    set_pred(1'b0, 32'h0, NOP);
    set_upd(1'b0, 32'h40, 4'b0101, 1'b1, 1'b1);
    tick();
    set_upd(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    check("ghr_after_jal_alu_stray", pred_ghr_out, 4'b1011);

    // Async reset between edges, then updates during INIT are dropped.
    set_pred(1'b0, 32'h100, j_inst(32'h20));
    #1 rst = 1'b0;
    #1;
    check("async_rst_ready", pred_ready_out, 0);
    check("async_rst_ghr", pred_ghr_out, 0);
    check("async_rst_taken", pred_taken_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_ready(1'b1);
    set_pred(1'b0, 32'h40, b_inst(8));
    #1;
    check("init_upd_dropped", pred_taken_out, 0);
    check("init_misp_ghr", pred_ghr_out, 0);
    set_pred(1'b0, 32'h54, b_inst(8));
    #1;
    check("reinit_idx5", pred_taken_out, 0);

    // Bimodal ignores history in the index; gshare does not.
    check("bim_ready", b_ready, 1);
    set_pred(1'b0, 32'h40, b_inst(8));
    do_update(32'h40, 4'h0, 1'b1);
    check("bim_inc", b_taken, 1);
    do_update(32'h40, 4'hF, 1'b0);
    check("bim_same_entry", b_taken, 0);
    check("gshare_diff_entry", pred_taken_out, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
